// File: rtl/pulse_stretcher.sv
// Stretches one-clock event pulses into fixed-width output pulses separated by a fixed gap, queueing overlap.
// Optional synchronous clear input enabled by defining PULSE_STRETCH_CLEAR_EN.
module pulse_stretcher #(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 10_000_000,
    parameter int PEND_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pulse_in,
`ifdef PULSE_STRETCH_CLEAR_EN
    input  logic              clear,
`endif
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0]     HOLD_LD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]     GAP_LD  = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : TW'(0);
    localparam logic [TW-1:0]     T_ZERO  = TW'(0);
    localparam logic [TW-1:0]     T_ONE   = TW'(1);
    localparam logic [PEND_W-1:0] P_ZERO  = PEND_W'(0);
    localparam logic [PEND_W-1:0] P_ONE   = PEND_W'(1);
    localparam logic [PEND_W-1:0] P_MAX   = {PEND_W{1'b1}};

    if (HOLD_CYCLES < 1) begin : g_hold_check
        $error("pulse_stretcher: HOLD_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              out_q, out_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic              clear_s;
    logic              end_gap_s;
    logic              consume_s;
    logic              dequeue_s;
    logic              enqueue_s;

`ifdef PULSE_STRETCH_CLEAR_EN
    assign clear_s = clear;
`else
    assign clear_s = 1'b0;
`endif

    // Next-state, timer and queue bookkeeping; an incoming pulse is either consumed or queued.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pending_d  = pending_q;
        overflow_d = 1'b0;
        end_gap_s  = 1'b0;
        consume_s  = 1'b0;
        dequeue_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pulse_in) begin
                    state_d   = S_HOLD;
                    timer_d   = HOLD_LD;
                    consume_s = 1'b1;
                end else begin
                    timer_d = T_ZERO;
                end
            end
            S_HOLD: begin
                if (timer_q == T_ZERO) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        timer_d = GAP_LD;
                    end else begin
                        end_gap_s = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_GAP: begin
                if (timer_q == T_ZERO) begin
                    end_gap_s = 1'b1;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = T_ZERO;
            end
        endcase

        // Queued events take precedence; a fresh pulse is only consumed when the queue is empty.
        if (end_gap_s) begin
            if ((pending_q != P_ZERO) || pulse_in) begin
                state_d = S_HOLD;
                timer_d = HOLD_LD;
                if (pending_q != P_ZERO) begin
                    dequeue_s = 1'b1;
                end else begin
                    consume_s = 1'b1;
                end
            end else begin
                state_d = S_IDLE;
                timer_d = T_ZERO;
            end
        end else begin
            dequeue_s = 1'b0;
        end

        enqueue_s = pulse_in && !consume_s;

        if (enqueue_s && !dequeue_s) begin
            if (pending_q == P_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + P_ONE;
            end
        end else if (dequeue_s && !enqueue_s) begin
            pending_d = pending_q - P_ONE;
        end else begin
            pending_d = pending_q;
        end

        if (clear_s) begin
            state_d    = S_IDLE;
            timer_d    = T_ZERO;
            pending_d  = P_ZERO;
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_d;
        end

        out_d  = (state_d == S_HOLD);
        busy_d = (state_d != S_IDLE);
    end

    // State, timer, queue and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= T_ZERO;
            pending_q  <= P_ZERO;
            out_q      <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule
